bitblt_addr_div_seq: RTL and testbench

- Sequential unsigned divider that inverts the bitblt address multiply: it recovers (y, x) from a linear pixel address as address / width and address % width.
- Used on the read-back side of the bitblt engine, where a flat frame-buffer offset must be turned into row and column coordinates.
- Restoring division, one quotient bit per clock, with valid/ready handshakes on both input and output.
- One operation in flight at a time.

---
 rtl/bitblt_pkg.sv | 10 +
 rtl/bitblt_div_step.sv | 23 ++
 rtl/bitblt_addr_div_seq.sv | 121 ++++++++++++
 tb/tb_bitblt_addr_div_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bitblt_pkg.sv
// Shared types and constants for the bitblt address divider.
package bitblt_pkg;
  localparam int ADDR_W  = 22;
  localparam int COORD_W = 11;
  localparam int QUO_W   = ADDR_W - COORD_W;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [QUO_W-1:0] OVF_QUOTIENT = '1;
endpackage

// File: rtl/bitblt_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module bitblt_div_step #(
  parameter int R_W = 11,
  parameter int Q_W = 11
) (
  input  logic [R_W-1:0] r,
  input  logic [Q_W-1:0] q,
  input  logic [R_W-1:0] divisor,
  output logic [R_W-1:0] r_next,
  output logic [Q_W-1:0] q_next
);
  logic [R_W:0] t;
  logic [R_W:0] d;
  logic         ge;

  assign t  = {r, q[Q_W-1]};
  assign d  = {1'b0, divisor};
  assign ge = (t >= d);

  // r < divisor on entry, so t - d always fits back into R_W bits.
  assign r_next = ge ? R_W'(t - d) : t[R_W-1:0];
  assign q_next = {q[Q_W-2:0], ge};
endmodule

// File: rtl/bitblt_addr_div_seq.sv
// Sequential restoring divider: linear address -> (row, column) = (addr / width, addr % width).
module bitblt_addr_div_seq
  import bitblt_pkg::*;
#(
  parameter int DIVIDEND_W = ADDR_W,
  parameter int DIVISOR_W  = COORD_W
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DIVIDEND_W-1:0]          dividend,
  input  logic [DIVISOR_W-1:0]           divisor,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DIVIDEND_W-DIVISOR_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]           remainder,
  output logic                           ovf
);
  localparam int QW    = DIVIDEND_W - DIVISOR_W;
  localparam int CNT_W = $clog2(QW + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(QW - 1);

  state_t               state, state_n;
  logic [DIVISOR_W-1:0] r, r_n, r_step;
  logic [QW-1:0]        q, q_n, q_step;
  logic [DIVISOR_W-1:0] div, div_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [QW-1:0]        quo_n;
  logic [DIVISOR_W-1:0] rem_n;
  logic                 ovf_n;
  logic                 in_ready_n, out_valid_n;

  logic [DIVISOR_W-1:0] hi;
  logic [QW-1:0]        lo;

  assign hi = dividend[DIVIDEND_W-1:QW];
  assign lo = dividend[QW-1:0];

  bitblt_div_step #(.R_W(DIVISOR_W), .Q_W(QW)) u_step (
    .r       (r),
    .q       (q),
    .divisor (div),
    .r_next  (r_step),
    .q_next  (q_step)
  );

  always_comb begin
    state_n = state;
    r_n     = r;
    q_n     = q;
    div_n   = div;
    cnt_n   = cnt;
    quo_n   = quotient;
    rem_n   = remainder;
    ovf_n   = ovf;
    case (state)
      IDLE: begin
        if (in_valid) begin
          div_n = divisor;
          cnt_n = '0;
          // High half >= divisor means the quotient needs more than QW bits; also catches /0.
          if (hi >= divisor) begin
            state_n = DONE;
            ovf_n   = 1'b1;
            quo_n   = '1;
            rem_n   = '0;
          end else begin
            state_n = CALC;
            r_n     = hi;
            q_n     = lo;
            ovf_n   = 1'b0;
          end
        end
      end
      CALC: begin
        r_n   = r_step;
        q_n   = q_step;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = DONE;
          cnt_n   = '0;
          quo_n   = q_step;
          rem_n   = r_step;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      r         <= '0;
      q         <= '0;
      div       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      q         <= q_n;
      div       <= div_n;
      cnt       <= cnt_n;
      quotient  <= quo_n;
      remainder <= rem_n;
      ovf       <= ovf_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
    end
  end
endmodule

// File: tb/tb_bitblt_addr_div_seq.sv
// Self-checking bench for bitblt_addr_div_seq: directed cases plus random vectors vs a / and % model.
module tb_bitblt_addr_div_seq;
  import bitblt_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_ready;
  logic [ADDR_W-1:0]  dividend;
  logic [COORD_W-1:0] divisor;
  logic               out_valid, out_ready;
  logic [QUO_W-1:0]   quotient;
  logic [COORD_W-1:0] remainder;
  logic               ovf;

  int n_vec = 0;
  int n_err = 0;

  bitblt_addr_div_seq dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: row/column by plain integer division, saturating when the row won't fit.
  task automatic model(input int unsigned a, input int unsigned b,
                       output int unsigned q, output int unsigned r, output bit o);
    if (b == 0 || a / b > 2047) begin
      q = OVF_QUOTIENT; r = 0; o = 1'b1;
    end else begin
      q = a / b; r = a % b; o = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".in_ready"},  in_ready,  1);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".quotient"},  quotient,  0);
    chk({tag, ".remainder"}, remainder, 0);
    chk({tag, ".ovf"},       ovf,       0);
  endtask

  // One full transaction; hold = cycles out_ready stays low after out_valid rises.
  task automatic do_op(input int unsigned a, input int unsigned b, input int hold, input bit junk);
    int unsigned eq, er;
    bit          eo;
    int          cyc;
    logic [QUO_W-1:0]   q_seen;
    logic [COORD_W-1:0] r_seen;
    model(a, b, eq, er, eo);
    @(negedge clk);
    chk("in_ready_before", in_ready, 1);
    dividend  = ADDR_W'(a);
    divisor   = COORD_W'(b);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
      // Scramble operands after acceptance; they must be ignored.
      in_valid = junk;
      dividend = ADDR_W'($urandom);
      divisor  = COORD_W'($urandom);
      if (!out_valid) chk("in_ready_busy", in_ready, 0);
    end while (!out_valid && cyc < 40);
    chk("latency", cyc, eo ? 1 : 12);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("ovf", ovf, eo);
    q_seen = quotient;
    r_seen = remainder;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold.out_valid", out_valid, 1);
      chk("hold.quotient", quotient, q_seen);
      chk("hold.remainder", remainder, r_seen);
      chk("hold.in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post.out_valid", out_valid, 0);
    chk("post.in_ready", in_ready, 1);
  endtask

  initial begin
    int unsigned a, b;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    do_op(192017, 640, 0, 1'b0);
    do_op(4192255, 2047, 0, 1'b0);
    do_op(20480, 10, 0, 1'b0);
    do_op(5, 0, 0, 1'b0);
    do_op(2096128, 2047, 0, 1'b0);
    do_op(1000, 10, 6, 1'b1);

    // Abort mid-calculation: outputs must drop without waiting for a clock.
    @(negedge clk);
    dividend = 22'd192017; divisor = 11'd640; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold.out_valid", out_valid, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (14) begin
      @(posedge clk); #1;
      chk("after_rst.out_valid", out_valid, 0);
    end
    do_op(7, 3, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0:       b = 0;
        1:       b = $urandom_range(1, 4);
        2:       b = 2047;
        default: b = $urandom_range(1, 2047);
      endcase
      if (b != 0 && $urandom_range(0, 3) != 0)
        a = $urandom_range(0, b * 2048 - 1);
      else
        a = $urandom_range(0, (1 << ADDR_W) - 1);
      do_op(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
